alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc_pkg.sv | 27 ++
 rtl/alu_mc_mul.sv | 72 +++++++
 rtl/alu_mc.sv | 161 ++++++++++++++++
 tb/tb_alu_mc.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared opcode constants, FSM state encoding and flag layout for alu_mc.
package alu_mc_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_RSV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic neg;
        logic zero;
    } flags_t;

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start          load a/b and begin WIDTH iterations
//   a, b           multiplicand / multiplier (sampled on start)
//   done           high during the cycle whose edge performs the last iteration
//   prod_c         product value after this cycle's iteration (final when done)
module alu_mc_mul
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod_c
);

    localparam int unsigned WP1 = WIDTH + 1;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic [WP1-1:0]   sum_c;
    logic [WIDTH-1:0] hi_n_c;
    logic [WIDTH-1:0] lo_n_c;

    // One step: conditionally add multiplicand, then shift {carry,hi,lo} right.
    always_comb begin
        sum_c  = WP1'(hi);
        if (lo[0]) begin
            sum_c = WP1'(hi) + WP1'(mcand);
        end
        hi_n_c = sum_c[WIDTH:1];
        lo_n_c = {sum_c[0], lo[WIDTH-1:1]};
        prod_c = {hi_n_c, lo_n_c};
    end

    // Iteration state; done is raised one cycle ahead so it covers the final step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (start) begin
            mcand <= a;
            hi    <= '0;
            lo    <= b;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else if (busy) begin
            hi   <= hi_n_c;
            lo   <= lo_n_c;
            cnt  <= cnt + CNT_W'(1);
            done <= (cnt == CNT_W'(WIDTH - 2));
            if (cnt == CNT_W'(WIDTH - 1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake on both sides.
// Single-cycle add/sub/logic ops go through EXEC; mul runs WIDTH cycles in
// the alu_mc_mul sub-module. Results are held in DONE until out_ready.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid, in_ready   request handshake (in_ready only in IDLE)
//   op, a, b             opcode and operands, latched on accept
//   out_valid, out_ready result handshake (out_valid only in DONE)
//   res_lo, res_hi       result (res_hi is the mul high half, else 0)
//   flags                {cout, ovf, neg, zero}
//   err                  reserved opcode executed
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [3:0]       flags,
    output logic             err
);

    localparam int unsigned WP1 = WIDTH + 1;

    state_t             state;
    state_t             state_n;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    flags_t             flags_q;

    logic               accept_c;
    logic               mul_start_c;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod_c;
    flags_t             mul_flags_c;

    logic [WIDTH-1:0]   nb_c;
    logic [WP1-1:0]     sum_c;
    logic [WIDTH-1:0]   alu_lo_c;
    flags_t             alu_flags_c;
    logic               alu_err_c;

    assign accept_c    = in_valid && in_ready;
    assign mul_start_c = accept_c && (op == OP_MUL);
    assign flags       = flags_q;

    alu_mc_mul #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start_c),
        .a      (a),
        .b      (b),
        .done   (mul_done),
        .prod_c (mul_prod_c)
    );

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept_c) state_n = (op == OP_MUL) ? MUL : EXEC;
            EXEC: state_n = DONE;
            MUL:  if (mul_done) state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Single-cycle datapath on the latched operands; sub is a + ~b + 1.
    always_comb begin
        nb_c        = ~b_q;
        sum_c       = '0;
        alu_lo_c    = '0;
        alu_flags_c = '0;
        alu_err_c   = 1'b0;
        case (op_q)
            OP_ADD: begin
                sum_c            = WP1'(a_q) + WP1'(b_q);
                alu_lo_c         = sum_c[WIDTH-1:0];
                alu_flags_c.cout = sum_c[WIDTH];
                alu_flags_c.ovf  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                   (alu_lo_c[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                sum_c            = WP1'(a_q) + WP1'(nb_c) + WP1'(1);
                alu_lo_c         = sum_c[WIDTH-1:0];
                alu_flags_c.cout = sum_c[WIDTH];
                alu_flags_c.ovf  = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                   (alu_lo_c[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  alu_lo_c = a_q & b_q;
            OP_OR:   alu_lo_c = a_q | b_q;
            OP_XOR:  alu_lo_c = a_q ^ b_q;
            OP_NOT:  alu_lo_c = ~a_q;
            OP_RSV:  alu_err_c = 1'b1;
            default: alu_lo_c = '0;
        endcase
        // Reserved op leaves alu_lo_c at 0, so it naturally yields flags 4'b0001.
        alu_flags_c.neg  = alu_lo_c[WIDTH-1];
        alu_flags_c.zero = (alu_lo_c == '0);
    end

    // Mul flags are taken from the final product as it is written.
    always_comb begin
        mul_flags_c      = '0;
        mul_flags_c.cout = |mul_prod_c[2*WIDTH-1:WIDTH];
        mul_flags_c.neg  = mul_prod_c[2*WIDTH-1];
        mul_flags_c.zero = (mul_prod_c == '0);
    end

    // State, handshake outputs, operand latches and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_lo    <= '0;
            res_hi    <= '0;
            flags_q   <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            in_ready  <= (state_n == IDLE);
            out_valid <= (state_n == DONE);
            if (accept_c) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
            end
            if (state == EXEC) begin
                res_lo  <= alu_lo_c;
                res_hi  <= '0;
                flags_q <= alu_flags_c;
                err     <= alu_err_c;
            end else if ((state == MUL) && mul_done) begin
                res_lo  <= mul_prod_c[WIDTH-1:0];
                res_hi  <= mul_prod_c[2*WIDTH-1:WIDTH];
                flags_q <= mul_flags_c;
                err     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Randomized scoreboard bench for alu_mc (WIDTH=16). The driver pushes the
// expected response of each accepted request; the monitor pops it when the
// DUT presents out_valid and also applies backpressure on out_ready.
module tb_alu_mc;

    localparam int W = 16;
    localparam longint unsigned MOD  = 64'd65536;
    localparam longint unsigned HALF = 64'd32768;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic [3:0]  fl;
        logic        er;
        int          acc;
        int          lat;
        int          stall;
        logic [2:0]  op;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] res_lo;
    logic [15:0] res_hi;
    logic [3:0]  flags;
    logic        err;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   mon_busy = 1'b0;
    exp_t q[$];

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_lo    (res_lo),
        .res_hi    (res_hi),
        .flags     (flags),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got hang required finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference behaviour from plain integer arithmetic.
    function automatic void model(input logic [2:0] o, input longint unsigned ua,
                                  input longint unsigned ub, output logic [15:0] lo,
                                  output logic [15:0] hi, output logic [3:0] fl,
                                  output logic er);
        longint unsigned r;
        longint sa, sb, sr;
        logic cout, ovf, neg, zero;
        sa = (ua >= HALF) ? longint'(ua) - longint'(MOD) : longint'(ua);
        sb = (ub >= HALF) ? longint'(ub) - longint'(MOD) : longint'(ub);
        lo = '0; hi = '0; cout = 1'b0; ovf = 1'b0; er = 1'b0; r = 0;
        case (o)
            3'd0: begin
                r = ua + ub; lo = 16'(r % MOD); cout = (r >= MOD);
                sr = sa + sb; ovf = (sr > 32767) || (sr < -32768);
            end
            3'd1: begin
                r = (ua + MOD - ub) % MOD; lo = 16'(r); cout = (ua >= ub);
                sr = sa - sb; ovf = (sr > 32767) || (sr < -32768);
            end
            3'd2: begin
                r = ua * ub; lo = 16'(r % MOD); hi = 16'(r / MOD); cout = (hi != 0);
            end
            3'd3: er = 1'b1;
            3'd4: lo = 16'(ua & ub);
            3'd5: lo = 16'(ua | ub);
            3'd6: lo = 16'(ua ^ ub);
            default: lo = 16'(MOD - 1 - ua);
        endcase
        neg  = (o == 3'd2) ? hi[15] : lo[15];
        zero = (o == 3'd2) ? (r == 0) : (lo == 0);
        fl   = {cout, ovf, neg, zero};
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Wait for in_ready (scrambling inputs meanwhile), present one request and
    // record the accept cycle. Callers enter at a falling edge or just after accept.
    task automatic issue(input logic [2:0] o, input logic [15:0] ia, input logic [15:0] ib,
                         input int stall, input bit push);
        exp_t e;
        int n = 0;
        while (!in_ready && n < 500) begin
            a = 16'($urandom); b = 16'($urandom); op = 3'($urandom);
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_valid = 1'b1; op = o; a = ia; b = ib;
        @(posedge clk);
        #1;
        e.acc = cyc;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); op = 3'($urandom);
        model(o, longint'(ia), longint'(ib), e.lo, e.hi, e.fl, e.er);
        e.lat   = (o == 3'd2) ? W + 1 : 2;
        e.stall = stall;
        e.op    = o;
        if (push) q.push_back(e);
    endtask

    task automatic chk_reset_state(input string nm);
        chk(nm, 64'({in_ready, out_valid, res_hi, res_lo, flags, err}),
            64'({1'b1, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0}));
    endtask

    // Monitor: pop expected entry, wait for out_valid, check, apply stall, handshake.
    initial begin
        exp_t e;
        int n;
        int lat;
        logic [36:0] snap;
        forever begin
            @(negedge clk);
            while (q.size() == 0) @(negedge clk);
            e = q.pop_front();
            mon_busy = 1'b1;
            n = 0;
            while (!out_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!out_valid) begin
                chk("out_valid_timeout", 64'(out_valid), 64'd1);
            end else begin
                // Rising edges from accept to the first edge presenting out_valid.
                lat = cyc - e.acc + 1;
                chk($sformatf("latency op%0d", e.op), 64'(lat), 64'(e.lat));
                chk($sformatf("result op%0d", e.op),
                    64'({in_ready, res_hi, res_lo, flags, err}),
                    64'({1'b0, e.hi, e.lo, e.fl, e.er}));
                snap = {res_hi, res_lo, flags, err};
                for (int k = 0; k < e.stall; k++) begin
                    @(negedge clk);
                    chk("stall_hold", 64'({out_valid, in_ready, res_hi, res_lo, flags, err}),
                        64'({1'b1, 1'b0, snap}));
                end
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                chk("after_handshake", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
            end
            mon_busy = 1'b0;
        end
    end

    // Driver.
    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk_reset_state("reset_state");
        rst_n = 1'b1;
        issue(3'd0, 16'hFFFF, 16'h0001, 0, 1'b1);
        issue(3'd1, 16'h8000, 16'h0001, 1, 1'b1);
        issue(3'd2, 16'hFFFF, 16'hFFFF, 0, 1'b1);
        issue(3'd6, 16'hA5A5, 16'hA5A5, 5, 1'b1);
        issue(3'd3, 16'h1234, 16'h5678, 2, 1'b1);
        issue(3'd0, 16'h0001, 16'h0001, 0, 1'b1);
        // Reset in the middle of a multiply: the result must be discarded.
        issue(3'd2, 16'h1234, 16'h4321, 0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_state("reset_mid_mul");
        @(negedge clk);
        chk_reset_state("reset_held");
        rst_n = 1'b1;
        issue(3'd4, 16'h0F0F, 16'h00FF, 0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 3), 1'b1);
        end
        n = 0;
        while ((q.size() != 0 || mon_busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || mon_busy) chk("drain_timeout", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
